// File: rtl/perceptron_pkg.sv
// rtl/perceptron_pkg.sv - shared constants, FSM states and 16-bit clamp for the perceptron datapath
package perceptron_pkg;

  localparam int NUM_MULTS  = 16;
  localparam int PROD_W     = 16;
  localparam int ACC_W      = 22;
  localparam int SETTLE_CYC = 3;
  localparam logic [15:0] BIAS = 16'h0800;

  localparam int IDX_W = $clog2(NUM_MULTS);
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  localparam logic signed [ACC_W-1:0] BIAS_EXT  = ACC_W'($signed(BIAS));
  localparam logic signed [ACC_W-1:0] CLAMP_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] CLAMP_MIN = ACC_W'(-32768);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ACCUM = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic        sat;
    logic [15:0] value;
  } clamp_t;

  function automatic clamp_t clamp16(input logic signed [ACC_W-1:0] a);
    clamp_t r;
    if (a > CLAMP_MAX) begin
      r.sat   = 1'b1;
      r.value = 16'h7FFF;
    end else if (a < CLAMP_MIN) begin
      r.sat   = 1'b1;
      r.value = 16'h8000;
    end else begin
      r.sat   = 1'b0;
      r.value = a[15:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/sat_clamp.sv
// rtl/sat_clamp.sv - saturate a signed accumulator to 16 bits and flag when clamping occurred
module sat_clamp
  import perceptron_pkg::*;
(
  input  logic signed [ACC_W-1:0] din,
  output logic        [15:0]      dout,
  output logic                    sat
);

  clamp_t res;

  assign res  = clamp16(din);
  assign dout = res.value;
  assign sat  = res.sat;

endmodule

// File: rtl/dot_accumulator.sv
// rtl/dot_accumulator.sv - sequential bias + sum-of-products reduction with saturated 16-bit output
module dot_accumulator
  import perceptron_pkg::*;
(
  input  logic                          clk_12MHz,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_MULTS*PROD_W-1:0]   product_flat,
  output logic                          busy,
  output logic                          sum_valid,
  output logic signed [ACC_W-1:0]       sum,
  output logic [15:0]                   activation_input,
  output logic                          sat
);

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt;
  logic [IDX_W-1:0]        idx;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] addend;
  logic [PROD_W-1:0]       snap [NUM_MULTS];
  logic                    snap_en;
  logic [15:0]             clamp_val;
  logic                    clamp_sat;

  assign busy    = (state != ST_IDLE);
  assign snap_en = (state == ST_WAIT) && (cnt == '0) && !start;
  assign addend  = ACC_W'($signed(snap[idx]));

  sat_clamp u_sat_clamp (
    .din  (acc),
    .dout (clamp_val),
    .sat  (clamp_sat)
  );

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // A start in any state restarts settling; DONE's own update still lands in the datapath.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  state_nxt = ST_IDLE;
      ST_WAIT:  if (cnt == '0) state_nxt = ST_ACCUM;
      ST_ACCUM: if (idx == IDX_W'(NUM_MULTS - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_WAIT;
  end

  always_ff @(posedge clk_12MHz or negedge rst_n) begin
    if (!rst_n) begin
      cnt              <= '0;
      idx              <= '0;
      acc              <= '0;
      sum              <= '0;
      activation_input <= '0;
      sat              <= 1'b0;
      sum_valid        <= 1'b0;
    end else begin
      sum_valid <= 1'b0;
      if (start)
        cnt <= CNT_W'(SETTLE_CYC - 1);
      else if (state == ST_WAIT && cnt != '0)
        cnt <= cnt - 1'b1;

      if (snap_en) begin
        acc <= BIAS_EXT;
        idx <= '0;
      end else if (state == ST_ACCUM && !start) begin
        acc <= acc + addend;
        idx <= idx + 1'b1;
      end

      if (state == ST_DONE) begin
        sum              <= acc;
        activation_input <= clamp_val;
        sat              <= clamp_sat;
        sum_valid        <= 1'b1;
      end
    end
  end

  // Products are frozen here so upstream can move on to the next image immediately.
  always_ff @(posedge clk_12MHz) begin
    if (snap_en) begin
      for (int i = 0; i < NUM_MULTS; i++)
        snap[i] <= product_flat[PROD_W*i +: PROD_W];
    end
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// tb/tb_dot_accumulator.sv - self-checking bench for dot_accumulator against a sum-of-products model
module tb_dot_accumulator;

  logic               clk_12MHz = 1'b0;
  logic               rst_n;
  logic               start;
  logic [255:0]       product_flat;
  logic               busy;
  logic               sum_valid;
  logic signed [21:0] sum;
  logic [15:0]        activation_input;
  logic               sat;

  int checks   = 0;
  int failures = 0;

  logic signed [21:0] prev_sum;
  logic [15:0]        prev_act;
  logic               prev_sat;

  dot_accumulator dut (
    .clk_12MHz        (clk_12MHz),
    .rst_n            (rst_n),
    .start            (start),
    .product_flat     (product_flat),
    .busy             (busy),
    .sum_valid        (sum_valid),
    .sum              (sum),
    .activation_input (activation_input),
    .sat              (sat)
  );

  always #5 clk_12MHz = ~clk_12MHz;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    return {16{v}};
  endfunction

  function automatic logic [255:0] rand_flat(input bit big);
    logic [255:0] f;
    for (int i = 0; i < 16; i++)
      f[16*i +: 16] = big ? 16'($urandom_range(32767, 20000) * (($urandom & 1) ? 1 : -1))
                          : 16'($urandom);
    return f;
  endfunction

  function automatic longint model_sum(input logic [255:0] f);
    longint s = 2048;
    for (int i = 0; i < 16; i++)
      s += longint'($signed(f[16*i +: 16]));
    return s;
  endfunction

  function automatic logic [15:0] model_act(input longint s);
    longint t = s;
    if (s > 32767)  return 16'h7FFF;
    if (s < -32768) return 16'h8000;
    return t[15:0];
  endfunction

  task automatic pulse_start(input logic [255:0] flat);
    @(negedge clk_12MHz);
    product_flat = flat;
    start = 1'b1;
    @(negedge clk_12MHz);
    start = 1'b0;
  endtask

  // Entered just after the start-sampling edge; scrambles inputs after the snapshot when asked.
  task automatic expect_pass(input string tag, input logic [255:0] flat, input bit scramble);
    longint exp_s = model_sum(flat);
    int     lat = 0;
    bit     busy_drop = 0;
    bit     moved = 0;
    chk({tag, "_busy_start"}, 64'(busy), 64'(1));
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk_12MHz);
      if (scramble && k == 5) product_flat = rand_flat(0);
      if (sum_valid) begin
        lat = k;
        break;
      end
      if (!busy) busy_drop = 1;
      if (sum !== prev_sum || activation_input !== prev_act || sat !== prev_sat) moved = 1;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(20));
    chk({tag, "_busy_hold"}, 64'(busy_drop), 64'(0));
    chk({tag, "_stable"}, 64'(moved), 64'(0));
    chk({tag, "_sum"}, $signed(sum), exp_s);
    chk({tag, "_act"}, 64'(activation_input), 64'(model_act(exp_s)));
    chk({tag, "_sat"}, 64'(sat), 64'((exp_s > 32767 || exp_s < -32768) ? 1 : 0));
    chk({tag, "_busy_end"}, 64'(busy), 64'(0));
    @(negedge clk_12MHz);
    chk({tag, "_pulse_1cyc"}, 64'(sum_valid), 64'(0));
    prev_sum = sum;
    prev_act = activation_input;
    prev_sat = sat;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_valid"}, 64'(sum_valid), 64'(0));
    chk({tag, "_sum"}, $signed(sum), 64'(0));
    chk({tag, "_act"}, 64'(activation_input), 64'(0));
    chk({tag, "_sat"}, 64'(sat), 64'(0));
  endtask

  initial begin
    logic [255:0] f;
    rst_n = 1'b0;
    start = 1'b1;
    product_flat = fill(16'h0001);
    prev_sum = '0;
    prev_act = '0;
    prev_sat = 1'b0;

    // Reset held with start asserted: everything stays quiet.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_12MHz);
      chk_zero("reset");
    end
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk_12MHz);
    chk_zero("post_reset");

    pulse_start(fill(16'h0001));
    expect_pass("ones", fill(16'h0001), 1'b0);
    chk("ones_const", $signed(sum), 64'(22'h000810));

    pulse_start(fill(16'h7FFF));
    expect_pass("maxpos", fill(16'h7FFF), 1'b1);
    chk("maxpos_const", $signed(sum), 64'(526320));

    pulse_start(fill(16'h8000));
    expect_pass("maxneg", fill(16'h8000), 1'b1);
    chk("maxneg_const", $signed(sum), -64'(522240));

    f = fill(16'hFFFF);
    f[16*3 +: 16] = 16'h0010;
    pulse_start(f);
    expect_pass("mixed", f, 1'b0);
    chk("mixed_const", 64'(activation_input), 64'(16'h0801));

    // Restart while ACCUM is at idx 5: only the second pass reports.
    pulse_start(rand_flat(0));
    repeat (7) @(negedge clk_12MHz);
    chk("abort_no_pulse", 64'(sum_valid), 64'(0));
    pulse_start(fill(16'h0002));
    expect_pass("restart", fill(16'h0002), 1'b0);
    chk("restart_const", $signed(sum), 64'(16'h0820));

    // Asynchronous reset in the middle of accumulation.
    pulse_start(rand_flat(1));
    repeat (8) @(negedge clk_12MHz);
    #2 rst_n = 1'b0;
    #1 chk_zero("mid_reset");
    start = 1'b1;
    @(negedge clk_12MHz);
    chk_zero("mid_reset_start");
    rst_n = 1'b1;
    start = 1'b0;
    prev_sum = '0;
    prev_act = '0;
    prev_sat = 1'b0;
    f = rand_flat(0);
    pulse_start(f);
    expect_pass("after_reset", f, 1'b1);

    for (int r = 0; r < 6; r++) begin
      f = rand_flat(r[0]);
      pulse_start(f);
      expect_pass($sformatf("rand%0d", r), f, r[1]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
